// File: rtl/divmod_seq.sv
// Sequential restoring divider: one quotient bit per clock, signed/unsigned,
// start/busy/done handshake and divide-by-zero reporting.
module divmod_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz_op;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Operand magnitudes and the trial subtraction for the current iteration
    always_comb begin
        w_a_mag = (signed_mode && a[WIDTH-1]) ? negate(a) : a;
        w_b_mag = (signed_mode && b[WIDTH-1]) ? negate(b) : b;
        w_shift = {r_rem, r_dvd[WIDTH-1]};
        // r_rem < r_dvs always, so the W+1-bit difference cannot overflow
        w_trial = w_shift - {1'b0, r_dvs};
    end

    // Control FSM, shift-subtract datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= {WIDTH{1'b0}};
            r_dvd       <= {WIDTH{1'b0}};
            r_dvs       <= {WIDTH{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz_op     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvs   <= w_b_mag;
                        r_rem   <= {WIDTH{1'b0}};
                        r_cnt   <= CNT_W'(WIDTH);
                        r_neg_q <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= signed_mode & a[WIDTH-1];
                        busy    <= 1'b1;
                        if (b == {WIDTH{1'b0}}) begin
                            // raw dividend kept for the remainder output
                            r_dz_op <= 1'b1;
                            r_dvd   <= a;
                            r_state <= FIN;
                        end else begin
                            r_dz_op <= 1'b0;
                            r_dvd   <= w_a_mag;
                            r_state <= CALC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CALC: begin
                    r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FIN;
                    end else begin
                        r_state <= CALC;
                    end
                end
                FIN: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
                    if (r_dz_op) begin
                        quotient    <= {WIDTH{1'b1}};
                        remainder   <= r_dvd;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= r_neg_q ? negate(r_dvd) : r_dvd;
                        remainder   <= r_neg_r ? negate(r_rem) : r_rem;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divmod_seq.sv
// Scoreboard bench for divmod_seq: a native-division model pushes expected
// results at issue, compared against the DUT when done pulses.
module tb_divmod_seq;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    divmod_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_mode(signed_mode),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                   input logic sm);
        exp_t   e;
        longint sa;
        longint sd;
        longint q;
        longint r;
        if (ib == '0) begin
            e.q  = '1;
            e.r  = ia;
            e.dz = 1'b1;
        end else begin
            if (sm) begin
                sa = longint'($signed(ia));
                sd = longint'($signed(ib));
            end else begin
                sa = longint'({32'd0, ia});
                sd = longint'({32'd0, ib});
            end
            q    = sa / sd;
            r    = sa % sd;
            e.q  = q[WIDTH-1:0];
            e.r  = r[WIDTH-1:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Issue one operation, optionally re-pulse start at cycle 'extra' after accept.
    task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic sm, input int extra);
        exp_t e;
        int   lat;
        int   exp_lat;
        exp_lat = (ib == '0) ? 1 : WIDTH + 1;
        sb_q.push_back(model(ia, ib, sm));
        @(negedge clk);
        a = ia; b = ib; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; signed_mode = ~sm;
        check_eq("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        for (int c = 1; c <= WIDTH + 6; c++) begin
            @(posedge clk); #1;
            if (c == extra) begin
                start = 1'b1; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("busy_at_done", 64'(busy), 64'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("quotient", 64'(quotient), 64'(e.q));
            check_eq("remainder", 64'(remainder), 64'(e.r));
            check_eq("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        end else begin
            check_eq("scoreboard_empty", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        check_eq("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_checks = 0; n_fail = 0;
        rst = 1'b1; start = 1'b1; signed_mode = 1'b0; a = 32'd100; b = 32'd7;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_quotient", 64'(quotient), 64'd0);
        check_eq("rst_remainder", 64'(remainder), 64'd0);
        check_eq("rst_dz", 64'(div_by_zero), 64'd0);
        start = 1'b0;
        @(negedge clk); rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        run_op(32'h1234_5678, 32'd0, 1'b0, 0);
        run_op(32'h1234_5678, 32'd0, 1'b1, 0);
        run_op(32'd9, 32'd3, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op(32'd5, 32'd9, 1'b1, 0);

        // Second start mid-operation must be ignored
        run_op(32'd50, 32'd5, 1'b0, 10);
        count_dones(WIDTH + 8, n);
        check_eq("no_extra_done", 64'(n), 64'd0);

        // Reset in the middle of a calculation aborts it
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_quotient", 64'(quotient), 64'd0);
        check_eq("abort_remainder", 64'(remainder), 64'd0);
        check_eq("abort_dz", 64'(div_by_zero), 64'd0);
        count_dones(WIDTH + 8, n);
        check_eq("abort_no_done", 64'(n), 64'd0);
        run_op(32'd20, 32'd6, 1'b0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if ($urandom_range(0, 7) == 0) rb = rb >> $urandom_range(1, 31);
            run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        check_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
